// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC interrupt gateway.
package plic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  localparam int unsigned PLIC_NO_SRC = 0;

  // IDs run 1..num_src with 0 reserved for "no source".
  function automatic int unsigned plic_id_w(input int unsigned num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/plic_gateway_array_if.sv
// Gateway bus: raw interrupt lines, mode, claim/complete strobes and per-source status.
interface plic_gateway_array_if
  import plic_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = plic_id_w(NUM_SRC)
);
  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] edge_mode;
  logic               claim_valid;
  logic [ID_W-1:0]    claim_id;
  logic               complete_valid;
  logic [ID_W-1:0]    complete_id;
  logic [NUM_SRC-1:0] ip;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] edge_drop;

  modport master (
    output irq_src, edge_mode, claim_valid, claim_id, complete_valid, complete_id,
    input  ip, in_service, edge_drop
  );

  modport slave (
    input  irq_src, edge_mode, claim_valid, claim_id, complete_valid, complete_id,
    output ip, in_service, edge_drop
  );
endinterface

// File: rtl/plic_gateway_ch.sv
// One gateway channel: synchroniser, edge detect, saturating pending counter and
// IDLE/PENDING/CLAIMED handshake FSM.
module plic_gateway_ch
  import plic_pkg::*;
#(
  parameter int unsigned PEND_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_raw,
  input  logic edge_mode,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic ip,
  output logic in_service,
  output logic edge_drop
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   det_q, det_d;
  logic                   prev_q, prev_d;
  logic                   mode_q, mode_d;
  logic [PEND_W-1:0]      cnt_q, cnt_d;
  gw_state_e              state_q, state_d;
  logic                   ip_q, ip_d;
  logic                   in_service_q, in_service_d;
  logic                   edge_drop_q, edge_drop_d;

  logic rise_c;
  logic claim_take_c;
  logic complete_take_c;

  // Sync chain, then one detect stage so both modes see the same source latency.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], irq_raw};
  assign det_d  = sync_q[SYNC_STAGES-1];
  assign prev_d = det_q;
  assign rise_c = det_q & ~prev_q;

  assign claim_take_c    = claim_hit    && (state_q == GW_PENDING);
  assign complete_take_c = complete_hit && (state_q == GW_CLAIMED);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = edge_mode;
    edge_drop_d = 1'b0;

    if (mode_d != mode_q) begin
      // Mode switch flushes the channel; ip stays low this cycle.
      state_d = GW_IDLE;
      cnt_d   = '0;
    end else begin
      if (mode_q) begin
        case ({rise_c, claim_take_c})
          2'b10: begin
            if (cnt_q == CNT_MAX) edge_drop_d = 1'b1;
            else                  cnt_d = cnt_q + PEND_W'(1);
          end
          2'b01: begin
            if (cnt_q != '0) cnt_d = cnt_q - PEND_W'(1);
          end
          default: cnt_d = cnt_q;
        endcase
      end else begin
        cnt_d = '0;
      end

      case (state_q)
        GW_IDLE: begin
          if (mode_q ? (cnt_d != '0) : det_q) state_d = GW_PENDING;
        end
        GW_PENDING: begin
          if (claim_take_c) state_d = GW_CLAIMED;
        end
        GW_CLAIMED: begin
          if (complete_take_c) state_d = GW_IDLE;
        end
        default: state_d = GW_IDLE;
      endcase
    end

    ip_d         = (state_d == GW_PENDING);
    in_service_d = (state_d == GW_CLAIMED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      det_q        <= 1'b0;
      prev_q       <= 1'b0;
      mode_q       <= mode_d;
      cnt_q        <= '0;
      state_q      <= GW_IDLE;
      ip_q         <= 1'b0;
      in_service_q <= 1'b0;
      edge_drop_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      det_q        <= det_d;
      prev_q       <= prev_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      ip_q         <= ip_d;
      in_service_q <= in_service_d;
      edge_drop_q  <= edge_drop_d;
    end
  end

  assign ip         = ip_q;
  assign in_service = in_service_q;
  assign edge_drop  = edge_drop_q;

endmodule

// File: rtl/plic_gateway_array.sv
// PLIC gateway array: one channel per source plus claim/complete ID decode.
module plic_gateway_array
  import plic_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned PEND_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  plic_gateway_array_if.slave  bus
);

  localparam int unsigned ID_W = plic_id_w(NUM_SRC);

  logic               claim_ok_c;
  logic               complete_ok_c;
  logic [NUM_SRC-1:0] ip_c;
  logic [NUM_SRC-1:0] in_service_c;
  logic [NUM_SRC-1:0] edge_drop_c;

  // ID 0 never selects a channel; IDs above NUM_SRC match no channel.
  assign claim_ok_c    = bus.claim_valid    && (bus.claim_id    != ID_W'(PLIC_NO_SRC));
  assign complete_ok_c = bus.complete_valid && (bus.complete_id != ID_W'(PLIC_NO_SRC));

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
    logic claim_hit_c;
    logic complete_hit_c;

    assign claim_hit_c    = claim_ok_c    && (bus.claim_id    == ID_W'(i + 1));
    assign complete_hit_c = complete_ok_c && (bus.complete_id == ID_W'(i + 1));

    plic_gateway_ch #(
      .PEND_W      (PEND_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .irq_raw      (bus.irq_src[i]),
      .edge_mode    (bus.edge_mode[i]),
      .claim_hit    (claim_hit_c),
      .complete_hit (complete_hit_c),
      .ip           (ip_c[i]),
      .in_service   (in_service_c[i]),
      .edge_drop    (edge_drop_c[i])
    );
  end

  assign bus.ip         = ip_c;
  assign bus.in_service = in_service_c;
  assign bus.edge_drop  = edge_drop_c;

endmodule

// File: tb/tb_plic_gateway_array.sv
// Testbench for plic_gateway_array: directed scenarios plus random traffic against a reference model.
module tb_plic_gateway_array;
  import plic_pkg::*;

  localparam int unsigned NS   = 8;
  localparam int unsigned PW   = 2;
  localparam int unsigned SS   = 2;
  localparam int unsigned IDW  = plic_id_w(NS);
  localparam int          CMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  plic_gateway_array_if #(.NUM_SRC(NS)) bus ();

  plic_gateway_array #(
    .NUM_SRC     (NS),
    .PEND_W      (PW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: per-source request/service flags, pending count, and a history of line samples.
  int              m_cnt  [NS];
  bit              m_req  [NS];
  bit              m_svc  [NS];
  bit              m_drop [NS];
  bit              m_mode [NS];
  logic [NS-1:0]   hist   [SS+2];
  int              drop_tally [NS];

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        m_cnt[i] = 0; m_req[i] = 0; m_svc[i] = 0; m_drop[i] = 0;
        m_mode[i] = bus.edge_mode[i];
      end
      for (int j = 0; j < SS + 2; j++) hist[j] = '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        bit lvl, rise, clm, cmp;
        int n;
        lvl  = hist[SS][i];
        rise = hist[SS][i] & ~hist[SS+1][i];
        m_drop[i] = 0;
        if (bus.edge_mode[i] != m_mode[i]) begin
          m_mode[i] = bus.edge_mode[i];
          m_req[i] = 0; m_svc[i] = 0; m_cnt[i] = 0;
        end else begin
          clm = bus.claim_valid && (int'(bus.claim_id) == i + 1) && m_req[i];
          cmp = bus.complete_valid && (int'(bus.complete_id) == i + 1) && m_svc[i];
          if (m_mode[i]) begin
            n = m_cnt[i] + int'(rise) - int'(clm);
            if (n > CMAX) begin n = CMAX; m_drop[i] = 1; end
            m_cnt[i] = n;
          end else begin
            n = 0;
            m_cnt[i] = 0;
          end
          if (m_req[i]) begin
            if (clm) begin m_req[i] = 0; m_svc[i] = 1; end
          end else if (m_svc[i]) begin
            if (cmp) m_svc[i] = 0;
          end else if (m_mode[i] ? (n > 0) : lvl) begin
            m_req[i] = 1;
          end
        end
      end
      for (int j = SS + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = bus.irq_src;
    end
  endtask

  function automatic logic [NS-1:0] exp_ip();
    for (int i = 0; i < NS; i++) exp_ip[i] = m_req[i];
  endfunction
  function automatic logic [NS-1:0] exp_svc();
    for (int i = 0; i < NS; i++) exp_svc[i] = m_svc[i];
  endfunction
  function automatic logic [NS-1:0] exp_drop();
    for (int i = 0; i < NS; i++) exp_drop[i] = m_drop[i];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NS; i++) drop_tally[i] += int'(bus.edge_drop[i]);
  endtask

  task automatic hs_idle();
    bus.claim_valid = 1'b0; bus.claim_id = '0;
    bus.complete_valid = 1'b0; bus.complete_id = '0;
  endtask

  task automatic do_claim(input int id);
    bus.claim_valid = 1'b1; bus.claim_id = IDW'(id);
    step();
    hs_idle();
  endtask

  task automatic do_complete(input int id);
    bus.complete_valid = 1'b1; bus.complete_id = IDW'(id);
    step();
    hs_idle();
  endtask

  task automatic pulse(input int b);
    bus.irq_src[b] = 1'b1;
    step();
    bus.irq_src[b] = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.edge_mode = '0;
    bus.irq_src = NS'($urandom);
    bus.claim_valid = 1'b1; bus.claim_id = IDW'(3);
    bus.complete_valid = 1'b1; bus.complete_id = IDW'(3);
    step(); step();
    checks++; if (bus.ip !== '0) begin failures++; $display("FAIL reset_ip got=%b exp=0", bus.ip); end
    checks++; if (bus.in_service !== '0) begin failures++; $display("FAIL reset_svc got=%b exp=0", bus.in_service); end
    checks++; if (bus.edge_drop !== '0) begin failures++; $display("FAIL reset_drop got=%b exp=0", bus.edge_drop); end
    bus.irq_src = '0;
    hs_idle();
    reset = 1'b0;
    repeat (5) step();
    checks++; if (bus.ip !== '0) begin failures++; $display("FAIL post_reset_ip got=%b exp=0", bus.ip); end
  endtask

  task automatic test_level();
    bus.irq_src[2] = 1'b1;
    step(); step(); step();
    checks++; if (bus.ip[2] !== 1'b0) begin failures++; $display("FAIL level_early got=%b exp=0", bus.ip[2]); end
    step();
    checks++; if (bus.ip[2] !== 1'b1) begin failures++; $display("FAIL level_latency got=%b exp=1", bus.ip[2]); end
    do_claim(3);
    checks++; if ({bus.ip[2], bus.in_service[2]} !== 2'b01) begin failures++; $display("FAIL level_claim got=%b exp=01", {bus.ip[2], bus.in_service[2]}); end
    step(); step();
    checks++; if ({bus.ip[2], bus.in_service[2]} !== 2'b01) begin failures++; $display("FAIL level_hold got=%b exp=01", {bus.ip[2], bus.in_service[2]}); end
    do_complete(3);
    checks++; if ({bus.ip[2], bus.in_service[2]} !== 2'b00) begin failures++; $display("FAIL level_complete got=%b exp=00", {bus.ip[2], bus.in_service[2]}); end
    step();
    checks++; if (bus.ip[2] !== 1'b1) begin failures++; $display("FAIL level_reraise got=%b exp=1", bus.ip[2]); end
    bus.irq_src[2] = 1'b0;
    repeat (4) step();
    checks++; if (bus.ip[2] !== 1'b1) begin failures++; $display("FAIL level_no_withdraw got=%b exp=1", bus.ip[2]); end
    do_claim(3); do_complete(3);
    step(); step();
    checks++; if ({bus.ip, bus.in_service} !== '0) begin failures++; $display("FAIL level_clean got=%b/%b exp=0", bus.ip, bus.in_service); end
  endtask

  task automatic test_edge();
    bus.edge_mode[0] = 1'b1;
    step(); step();
    repeat (3) pulse(0);
    repeat (4) step();
    checks++; if (bus.ip[0] !== 1'b1) begin failures++; $display("FAIL edge_pending got=%b exp=1", bus.ip[0]); end
    for (int r = 0; r < 3; r++) begin
      do_claim(1);
      checks++; if ({bus.ip[0], bus.in_service[0]} !== 2'b01) begin failures++; $display("FAIL edge_claim%0d got=%b exp=01", r, {bus.ip[0], bus.in_service[0]}); end
      do_complete(1);
      checks++; if (bus.in_service[0] !== 1'b0) begin failures++; $display("FAIL edge_complete%0d got=%b exp=0", r, bus.in_service[0]); end
      step();
      checks++; if (bus.ip[0] !== (r < 2)) begin failures++; $display("FAIL edge_reraise%0d got=%b exp=%b", r, bus.ip[0], (r < 2)); end
    end
  endtask

  task automatic test_saturation();
    int svc;
    bus.edge_mode[1] = 1'b1;
    step(); step();
    drop_tally[1] = 0;
    repeat (5) pulse(1);
    repeat (4) step();
    checks++; if (drop_tally[1] !== 2) begin failures++; $display("FAIL sat_drops got=%0d exp=2", drop_tally[1]); end
    svc = 0;
    repeat (6) begin
      if (bus.ip[1]) begin do_claim(2); do_complete(2); svc++; end
      step();
    end
    checks++; if (svc !== CMAX) begin failures++; $display("FAIL sat_services got=%0d exp=%0d", svc, CMAX); end
  endtask

  task automatic test_simul_rise_claim();
    drop_tally[1] = 0;
    pulse(1);
    repeat (4) step();
    checks++; if (bus.ip[1] !== 1'b1) begin failures++; $display("FAIL simul_setup got=%b exp=1", bus.ip[1]); end
    bus.irq_src[1] = 1'b1;
    step();
    bus.irq_src[1] = 1'b0;
    step(); step();
    do_claim(2);
    checks++; if ({bus.ip[1], bus.in_service[1]} !== 2'b01) begin failures++; $display("FAIL simul_claim got=%b exp=01", {bus.ip[1], bus.in_service[1]}); end
    do_complete(2);
    step();
    checks++; if (bus.ip[1] !== 1'b1) begin failures++; $display("FAIL simul_reraise got=%b exp=1", bus.ip[1]); end
    do_claim(2); do_complete(2);
    step();
    checks++; if (bus.ip[1] !== 1'b0) begin failures++; $display("FAIL simul_drained got=%b exp=0", bus.ip[1]); end
    checks++; if (drop_tally[1] !== 0) begin failures++; $display("FAIL simul_nodrop got=%0d exp=0", drop_tally[1]); end
  endtask

  task automatic test_illegal();
    bus.edge_mode[3] = 1'b1;
    step(); step();
    pulse(3);
    repeat (4) step();
    checks++; if ({bus.ip, bus.in_service} !== {8'h08, 8'h00}) begin failures++; $display("FAIL ill_setup got=%h/%h exp=08/00", bus.ip, bus.in_service); end
    do_claim(0);
    do_claim(9);
    do_claim(15);
    do_complete(5);
    do_complete(4);
    checks++; if ({bus.ip, bus.in_service} !== {8'h08, 8'h00}) begin failures++; $display("FAIL ill_ignored got=%h/%h exp=08/00", bus.ip, bus.in_service); end
    bus.claim_valid = 1'b1; bus.claim_id = IDW'(4);
    bus.complete_valid = 1'b1; bus.complete_id = IDW'(4);
    step();
    hs_idle();
    checks++; if ({bus.ip, bus.in_service} !== {8'h00, 8'h08}) begin failures++; $display("FAIL ill_same_cycle got=%h/%h exp=00/08", bus.ip, bus.in_service); end
    do_complete(4);
    step();
    do_complete(4);
    checks++; if ({bus.ip, bus.in_service} !== 16'h0) begin failures++; $display("FAIL ill_dup_complete got=%h/%h exp=00/00", bus.ip, bus.in_service); end
  endtask

  task automatic test_reset_mid();
    bus.edge_mode[5] = 1'b1;
    step(); step();
    repeat (3) pulse(5);
    repeat (4) step();
    do_claim(6);
    checks++; if (bus.in_service[5] !== 1'b1) begin failures++; $display("FAIL rmid_setup got=%b exp=1", bus.in_service[5]); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if ({bus.ip, bus.in_service, bus.edge_drop} !== '0) begin failures++; $display("FAIL rmid_outputs got=%h/%h/%h exp=0", bus.ip, bus.in_service, bus.edge_drop); end
    repeat (8) step();
    checks++; if ({bus.ip, bus.in_service} !== '0) begin failures++; $display("FAIL rmid_quiet got=%h/%h exp=0", bus.ip, bus.in_service); end
    pulse(5);
    repeat (4) step();
    checks++; if (bus.ip[5] !== 1'b1) begin failures++; $display("FAIL rmid_new_edge got=%b exp=1", bus.ip[5]); end
    do_claim(6); do_complete(6);
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      int q[$];
      if ($urandom_range(0, 199) == 0) bus.edge_mode[$urandom_range(0, NS-1)] ^= 1'b1;
      bus.irq_src ^= NS'($urandom & $urandom & $urandom);
      reset = ($urandom_range(0, 499) == 0);
      hs_idle();
      if ($urandom_range(0, 2) == 0) begin
        q.delete();
        for (int i = 0; i < NS; i++) if (m_req[i]) q.push_back(i + 1);
        bus.claim_valid = 1'b1;
        bus.claim_id = (q.size() > 0 && $urandom_range(0, 3) != 0)
                       ? IDW'(q[$urandom_range(0, q.size()-1)]) : IDW'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 2) == 0) begin
        q.delete();
        for (int i = 0; i < NS; i++) if (m_svc[i]) q.push_back(i + 1);
        bus.complete_valid = 1'b1;
        bus.complete_id = (q.size() > 0 && $urandom_range(0, 3) != 0)
                          ? IDW'(q[$urandom_range(0, q.size()-1)]) : IDW'($urandom_range(0, 15));
      end
      step();
      checks++; if (bus.ip !== exp_ip()) begin failures++; $display("FAIL rand_ip cyc=%0d got=%b exp=%b", c, bus.ip, exp_ip()); end
      checks++; if (bus.in_service !== exp_svc()) begin failures++; $display("FAIL rand_svc cyc=%0d got=%b exp=%b", c, bus.in_service, exp_svc()); end
      checks++; if (bus.edge_drop !== exp_drop()) begin failures++; $display("FAIL rand_drop cyc=%0d got=%b exp=%b", c, bus.edge_drop, exp_drop()); end
    end
    reset = 1'b0;
    hs_idle();
  endtask

  initial begin
    reset = 1'b1;
    bus.irq_src = '0;
    bus.edge_mode = '0;
    hs_idle();
    for (int i = 0; i < NS; i++) drop_tally[i] = 0;
    test_reset();
    test_level();
    test_edge();
    test_saturation();
    test_simul_rise_claim();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout reached without completing the test sequence");
    $fatal(1);
  end

endmodule

// File: doc/plic_gateway_array.md
# plic_gateway_array

Parametrised multi-source interrupt gateway for the PLIC: one gateway channel per interrupt source, each independently in level or edge mode. Each channel synchronises its raw source and counts edges in a saturating pending counter. It presents a single pending bit per source to the PLIC priority/arbitration logic, and it runs the claim/complete handshake by source ID. It sits between the raw peripheral interrupt lines and the PLIC core register/arbiter block.

## Interface
- `NUM_SRC`, 8: number of interrupt sources; IDs 1..NUM_SRC, ID 0 means "no source".
- `PEND_W`, 4: width of the per-source edge pending counter; saturates at 2^PEND_W-1.
- `SYNC_STAGES`, 2: synchroniser flops on each raw source (min 2).
- `ID_W`, $clog2(NUM_SRC+1): width of claim/complete IDs (derived; do not override).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `irq_src`  in  NUM_SRC  raw asynchronous interrupt lines; bit i = source ID i+1.
- `edge_mode`  in  NUM_SRC  1 = edge-triggered, 0 = level-triggered; quasi-static.
- `claim_valid`  in  1  one-cycle claim strobe from the PLIC core.
- `claim_id`  in  ID_W  source being claimed.
- `complete_valid`  in  1  one-cycle completion strobe.
- `complete_id`  in  ID_W  source being completed.
- `ip`  out  NUM_SRC  per-source interrupt-pending to the arbiter.
- `in_service`  out  NUM_SRC  per-source claimed-and-not-completed.
- `edge_drop`  out  NUM_SRC  one-cycle pulse: edge arrived while that counter was saturated.

## Operation
- Per channel: `SYNC_STAGES` flop synchroniser, then registered previous value; `rise = sync & ~prev`.
- Channel FSM, 3 states:
  - IDLE: ip=0, in_service=0.
  - PENDING: ip=1.
  - CLAIMED: ip=0, in_service=1.
- Level mode:
  - IDLE -> PENDING when `sync`=1.
  - PENDING -> CLAIMED on a matching claim.
  - CLAIMED -> IDLE on a matching complete.
  - If the line is still high after completion, the channel re-enters PENDING on the next cycle.
  - A line that drops while PENDING does not withdraw ip; the request stays until claimed.
- Edge mode, counter arithmetic:
  - `cnt_next = cnt + rise - (claim hit in PENDING)`, with saturation at max.
  - Simultaneous rise and claim: net 0.
  - Rise at max: counter holds and `edge_drop` pulses.
- Edge mode, FSM:
  - IDLE -> PENDING when `cnt_next` > 0.
  - PENDING -> CLAIMED on claim; the counter decrements by 1 in the same cycle.
  - CLAIMED -> IDLE on complete. Remaining counts re-raise ip on the following cycle.
  - Edges arriving in CLAIMED are counted, not lost.
- Handshake rules:
  - A claim hits only when `claim_id` is 1..NUM_SRC and that channel is PENDING. Otherwise it is ignored.
  - A complete hits only when that channel is CLAIMED. Otherwise it is ignored. Spurious or duplicate completes have no effect.
  - ID 0 and IDs > NUM_SRC are ignored.
  - Claim and complete to the same ID in the same cycle: complete ignored (the channel is PENDING, not CLAIMED); claim takes effect.
  - Claim and complete to different IDs in the same cycle: both act.
- Mode change: a change of `edge_mode[i]` vs its registered copy forces channel i to IDLE and clears its counter next cycle. No ip glitch results; ip=0 that cycle.

## Timing
- Reset (synchronous, active-high, 1 cycle min): all FSMs IDLE, counters 0, sync/prev flops 0.
- Outputs during and after reset: ip=0, in_service=0, edge_drop=0.
- Raw-source latency: irq_src high sampled at edge N -> ip=1 after edge N+SYNC_STAGES+1, in both modes.
- Claim at edge N -> ip=0 and in_service=1 after edge N.
- Complete at edge N -> in_service=0 after edge N.
- Re-raise:
  - Edge mode: with cnt>0 after completion, ip=1 after edge N+1.
  - Level mode: line high -> ip=1 after edge N+1.
- `edge_drop` is registered and aligned with the cycle the counter would have incremented.
- Reset asserted mid-operation discards all pending counts and claims. No outputs toggle other than going to 0.

## Structure
- Shared `plic_pkg`:
  - gateway state enum (IDLE/PENDING/CLAIMED);
  - `PLIC_NO_SRC` = 0;
  - an ID-width function.
- One sub-module `plic_gateway_ch`: a single channel containing the synchroniser, edge detect, counter and FSM. It takes the decoded `claim_hit`/`complete_hit` strobes.
- The top instantiates NUM_SRC channels with a generate loop and does the ID decode.

## Test plan
- Level: src 3 high at cycle 10 -> ip[2]=1 at cycle 13. Claim 3 -> ip=0, in_service=1. Complete 3 with line still high -> ip=1 one cycle later.
- Edge: 3 pulses on src 1 before claim -> cnt=3. Three claim/complete rounds each re-raise ip after 1 cycle. ip stays 0 after the third complete.
- Saturation (PEND_W=2): 5 pulses -> cnt=3, edge_drop pulses twice. Exactly 3 services are delivered.
- Simultaneous rise and claim on src 2 with cnt=1 -> cnt stays 1, state CLAIMED. Complete -> ip re-raised.
- Illegal handshake: claim ID 0 and ID 9 (NUM_SRC=8); complete to an IDLE source; same-cycle claim+complete to one PENDING source -> only the claim acts, no other state change.
- Reset mid-service with cnt=2 and in_service=1 -> all outputs 0 next cycle. No ip until a new source edge arrives.
